// File: rtl/ram_bus_bridge_pkg.sv
// Shared definitions for the RAM bus bridge.
// Holds the access-size encodings, the response entry layout and a helper
// that widens a read lane to 32 bits.
package ram_bus_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  // One response as stored in the response FIFO: {err, rdata[31:0]}.
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_entry_t;

  localparam int RSP_W = $bits(rsp_entry_t);

  // Zero- or sign-extend a right-aligned byte (is_half=0) or half (is_half=1).
  function automatic logic [31:0] extend_lane(input logic [15:0] v,
                                              input logic        is_half,
                                              input logic        sgn);
    logic msb;
    msb = sgn & (is_half ? v[15] : v[7]);
    if (is_half) return {{16{msb}}, v};
    return {{24{msb}}, v[7:0]};
  endfunction

endpackage

// File: rtl/ram_bus_bridge_if.sv
// Request/response bus between a requester and ram_bus_bridge.
// Ports: req_* (request channel), rsp_* (response channel).
//
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// a response transfers on a clock edge where rsp_valid && rsp_ready. A side
// holding valid high keeps its payload stable until the transfer edge.
// req_ready never depends on rsp_ready.
interface ram_bus_bridge_if #(
  parameter int ADDRWIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic                 req_signed;
  logic [1:0]           req_size;
  logic [ADDRWIDTH+1:0] req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_write, req_signed, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_signed, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_bus_bridge_rsp_fifo.sv
// ram_rsp_fifo: synchronous FIFO with a registered head entry.
// Ports: clk, reset_l, push_i/push_data_i (write side), pop_i (consume head),
//        valid_o/data_o (head entry, straight from flops).
// Total capacity is DEPTH: one head register plus a DEPTH-1 entry body ring.
// Push and pop in the same cycle are both performed.
module ram_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  localparam int BD = DEPTH - 1;
  localparam int PW = (BD > 1) ? $clog2(BD) : 1;
  localparam int CW = $clog2(BD + 1);

  logic [WIDTH-1:0] body_q [BD];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             head_v_q, head_v_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_take, body_enq, body_deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BD - 1)) ? '0 : p + PW'(1);
  endfunction

  // The head refills whenever it is empty or being popped; the body feeds it
  // first so order is kept, and a push bypasses straight into an empty head.
  assign head_take = !head_v_q || pop_i;
  assign body_deq  = head_take && (cnt_q != '0);
  assign body_enq  = push_i && !(head_take && (cnt_q == '0));

  always_comb begin
    head_v_d = head_v_q;
    head_d   = head_q;
    rd_d     = body_deq ? ptr_inc(rd_q) : rd_q;
    wr_d     = body_enq ? ptr_inc(wr_q) : wr_q;
    cnt_d    = cnt_q + CW'(body_enq) - CW'(body_deq);
    if (head_take) begin
      if (cnt_q != '0) begin
        head_v_d = 1'b1;
        head_d   = body_q[rd_q];
      end else if (push_i) begin
        head_v_d = 1'b1;
        head_d   = push_data_i;
      end else begin
        head_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      head_v_q <= 1'b0;
      head_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      head_v_q <= head_v_d;
      head_q   <= head_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Body storage needs no reset: the count says which slots are meaningful.
  always_ff @(posedge clk) begin
    if (body_enq) body_q[wr_q] <= push_data_i;
  end

  assign valid_o = head_v_q;
  assign data_o  = head_q;
endmodule

// File: rtl/ram_bus_bridge.sv
// ram_bus_bridge: front end of a single-port byte-enable 32-bit RAM.
// Ports: clk, reset_l (async active-low), bus (request/response slave),
//        ram_we/ram_addr/ram_wr_data (to RAM), ram_rd_data (RAM read data,
//        valid the cycle after the address edge).
// Requests are credit-limited so every accepted request has a guaranteed
// slot in the response FIFO; responses return in order.
module ram_bus_bridge
  import ram_bus_bridge_pkg::*;
#(
  parameter int ADDRWIDTH = 8,
  parameter int DEPTH     = 3
) (
  input  logic                 clk,
  input  logic                 reset_l,
  ram_bus_bridge_if.slave      bus,
  output logic [3:0]           ram_we,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [31:0]          ram_wr_data,
  input  logic [31:0]          ram_rd_data
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          alive_q;
  logic [CW-1:0] credits_q, credits_d;
  logic          accept, pop, legal;
  logic [3:0]    we_lanes;
  logic [1:0]    lane;

  // Request attributes held for the cycle in which RAM read data arrives.
  logic          inflight_q, p_write_q, p_signed_q, p_err_q;
  size_e         p_size_q;
  logic [1:0]    p_lane_q;

  logic [31:0]   rd_ext;
  rsp_entry_t    push_entry, head;
  logic          head_valid;

  assign bus.req_ready = alive_q && (credits_q != '0);
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = head_valid && bus.rsp_ready;
  assign lane          = bus.req_addr[1:0];
  assign ram_addr      = bus.req_addr[ADDRWIDTH+1:2];

  // Lane encode: byte-enables and replicated write data for the access size.
  always_comb begin
    legal       = 1'b0;
    we_lanes    = 4'b0000;
    ram_wr_data = bus.req_wdata;
    case (size_e'(bus.req_size))
      SZ_BYTE: begin
        legal       = 1'b1;
        we_lanes    = 4'b0001 << lane;
        ram_wr_data = {4{bus.req_wdata[7:0]}};
      end
      SZ_HALF: begin
        legal       = !lane[0];
        we_lanes    = lane[1] ? 4'b1100 : 4'b0011;
        ram_wr_data = {2{bus.req_wdata[15:0]}};
      end
      SZ_WORD: begin
        legal    = (lane == 2'b00);
        we_lanes = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

  assign ram_we = (accept && bus.req_write && legal) ? we_lanes : 4'b0000;

  // Take on accept, return on pop; both together cancel out.
  always_comb begin
    credits_d = credits_q;
    if (accept && !pop)      credits_d = credits_q - CW'(1);
    else if (!accept && pop) credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      alive_q    <= 1'b0;
      credits_q  <= CW'(DEPTH);
      inflight_q <= 1'b0;
      p_write_q  <= 1'b0;
      p_signed_q <= 1'b0;
      p_err_q    <= 1'b0;
      p_size_q   <= SZ_BYTE;
      p_lane_q   <= 2'b00;
    end else begin
      alive_q    <= 1'b1;
      credits_q  <= credits_d;
      inflight_q <= accept;
      if (accept) begin
        p_write_q  <= bus.req_write;
        p_signed_q <= bus.req_signed;
        p_err_q    <= !legal;
        p_size_q   <= size_e'(bus.req_size);
        p_lane_q   <= lane;
      end
    end
  end

  // Lane decode: pick the addressed lane of the RAM word and extend it.
  always_comb begin
    rd_ext = ram_rd_data;
    case (p_size_q)
      SZ_BYTE: rd_ext = extend_lane({8'h00, ram_rd_data[{p_lane_q, 3'b000} +: 8]},
                                    1'b0, p_signed_q);
      SZ_HALF: rd_ext = extend_lane(ram_rd_data[{p_lane_q[1], 4'b0000} +: 16],
                                    1'b1, p_signed_q);
      default: rd_ext = ram_rd_data;
    endcase
    push_entry.err   = p_err_q;
    push_entry.rdata = (p_err_q || p_write_q) ? 32'h0 : rd_ext;
  end

  ram_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset_l     (reset_l),
    .push_i      (inflight_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .valid_o     (head_valid),
    .data_o      (head)
  );

  assign bus.rsp_valid = head_valid;
  assign bus.rsp_err   = head.err;
  assign bus.rsp_rdata = head.rdata;
endmodule

// File: tb/tb_ram_bus_bridge.sv
// Self-checking bench for ram_bus_bridge with a behavioural byte-enable RAM.
module tb_ram_bus_bridge;
  import ram_bus_bridge_pkg::*;

  logic        clk;
  logic        reset_l;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;
  logic [31:0] ram_mem [256];

  ram_bus_bridge_if #(.ADDRWIDTH(8)) bus ();

  ram_bus_bridge #(.ADDRWIDTH(8), .DEPTH(3)) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .bus         (bus),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  // ---------------- clock / reset / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    ram_rd_data <= ram_mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          acc_q[$];
  int          total = 0;
  int          bad = 0;
  logic        lat_chk = 1'b1;
  logic        ready_chk = 1'b0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a response transfers on the next edge when valid && ready.
  initial begin
    logic [32:0] e;
    int          a;
    forever begin
      @(negedge clk);
      #2;
      if (reset_l && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got %h expected none", {bus.rsp_err, bus.rsp_rdata});
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp", {bus.rsp_err, bus.rsp_rdata}, e);
          if (lat_chk) chk("rsp_latency", 33'(cyc), 33'(a + 1));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic w, input logic s, input logic [1:0] sz,
                      input logic [9:0] a, input logic [31:0] wd, input logic [32:0] exp,
                      output logic [3:0] we_o, output logic [31:0] wr_o);
    int g = 0;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_signed = s;
    bus.req_size   = sz;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    #1;
    if (ready_chk) chk("req_ready_cont", {32'h0, bus.req_ready}, 33'h1);
    while (!bus.req_ready && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 33'h0, 33'h1);
    end else begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc + 1);
    end
    we_o = ram_we;
    wr_o = ram_wr_data;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_left", 33'(exp_q.size()), 33'h0);
  endtask

  logic [9:0]  b_addr [8];
  logic [1:0]  b_size [8];
  logic [32:0] b_exp  [8];

  // Back-to-back reads from the b_* table with rsp_ready low for `hold`
  // cycles; reports how many were accepted when the hold ended.
  task automatic burst(input int n, input int hold, output int n_hold, output logic rdy_hold);
    int idx = 0;
    n_hold   = 0;
    rdy_hold = 1'b1;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < hold + 100 && idx < n; c++) begin
      if (c == hold) bus.rsp_ready = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_signed = 1'b0;
      bus.req_size   = b_size[idx];
      bus.req_addr   = b_addr[idx];
      bus.req_wdata  = 32'h0;
      #1;
      if (c == hold) begin
        n_hold   = idx;
        rdy_hold = bus.req_ready;
      end
      if (bus.req_ready) begin
        exp_q.push_back(b_exp[idx]);
        acc_q.push_back(cyc + 1);
        idx++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("burst_all_accepted", 33'(idx), 33'(n));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  we;
    logic [31:0] wr;
    int          nh;
    logic        rh;
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
    ram_rd_data    = 32'h0;
    reset_l        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    #1;
    chk("reset_rsp_valid", {32'h0, bus.rsp_valid}, 33'h0);
    chk("reset_rsp", {bus.rsp_err, bus.rsp_rdata}, 33'h0);
    chk("reset_req_ready", {32'h0, bus.req_ready}, 33'h0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    #1;
    chk("ready_before_alive", {32'h0, bus.req_ready}, 33'h0);
    @(negedge clk);

    // Word write then byte reads of each lane.
    send(1'b1, 1'b0, SZ_WORD, 10'h010, 32'h11223344, 33'h0, we, wr);
    chk("word_we", {29'h0, we}, 33'hF);
    send(1'b0, 1'b0, SZ_BYTE, 10'h010, 32'h0, 33'h44, we, wr);
    send(1'b0, 1'b0, SZ_BYTE, 10'h011, 32'h0, 33'h33, we, wr);
    send(1'b0, 1'b0, SZ_BYTE, 10'h012, 32'h0, 33'h22, we, wr);
    send(1'b0, 1'b0, SZ_BYTE, 10'h013, 32'h0, 33'h11, we, wr);
    chk("read_we", {29'h0, we}, 33'h0);
    drain();

    // Byte write lane replication, signed/unsigned half reads.
    send(1'b1, 1'b0, SZ_WORD, 10'h014, 32'h0, 33'h0, we, wr);
    send(1'b1, 1'b0, SZ_BYTE, 10'h015, 32'h000000A5, 33'h0, we, wr);
    chk("byte_we", {29'h0, we}, 33'h2);
    chk("byte_wr_data", {1'b0, wr}, 33'h0A5A5A5A5);
    send(1'b0, 1'b1, SZ_HALF, 10'h014, 32'h0, 33'h0FFFFA500, we, wr);
    send(1'b0, 1'b0, SZ_HALF, 10'h014, 32'h0, 33'h00000A500, we, wr);
    drain();

    // Misaligned accesses: no RAM write, error responses in order.
    send(1'b1, 1'b0, SZ_HALF, 10'h021, 32'h0000BEEF, 33'h100000000, we, wr);
    chk("mis_half_we", {29'h0, we}, 33'h0);
    send(1'b0, 1'b0, SZ_WORD, 10'h022, 32'h0, 33'h100000000, we, wr);
    chk("mis_word_we", {29'h0, we}, 33'h0);
    send(1'b1, 1'b0, SZ_ILLEGAL, 10'h020, 32'hFFFFFFFF, 33'h100000000, we, wr);
    chk("illegal_we", {29'h0, we}, 33'h0);
    send(1'b0, 1'b0, SZ_WORD, 10'h020, 32'h0, 33'h0, we, wr);
    drain();

    // Backpressure: credits stop acceptance at 3.
    lat_chk = 1'b0;
    b_addr[0] = 10'h010; b_size[0] = SZ_BYTE; b_exp[0] = 33'h44;
    b_addr[1] = 10'h011; b_size[1] = SZ_BYTE; b_exp[1] = 33'h33;
    b_addr[2] = 10'h012; b_size[2] = SZ_BYTE; b_exp[2] = 33'h22;
    b_addr[3] = 10'h013; b_size[3] = SZ_BYTE; b_exp[3] = 33'h11;
    b_addr[4] = 10'h015; b_size[4] = SZ_BYTE; b_exp[4] = 33'hA5;
    burst(5, 6, nh, rh);
    chk("bp_accepted", 33'(nh), 33'h3);
    chk("bp_req_ready", {32'h0, rh}, 33'h0);
    drain();

    // Full throughput: 8 reads, one per cycle, responses one cycle later.
    lat_chk   = 1'b1;
    ready_chk = 1'b1;
    send(1'b0, 1'b0, SZ_BYTE, 10'h010, 32'h0, 33'h44, we, wr);
    send(1'b0, 1'b0, SZ_BYTE, 10'h011, 32'h0, 33'h33, we, wr);
    send(1'b0, 1'b0, SZ_BYTE, 10'h012, 32'h0, 33'h22, we, wr);
    send(1'b0, 1'b0, SZ_BYTE, 10'h013, 32'h0, 33'h11, we, wr);
    send(1'b0, 1'b0, SZ_WORD, 10'h010, 32'h0, 33'h011223344, we, wr);
    send(1'b0, 1'b1, SZ_HALF, 10'h012, 32'h0, 33'h000001122, we, wr);
    send(1'b0, 1'b0, SZ_HALF, 10'h010, 32'h0, 33'h000003344, we, wr);
    send(1'b0, 1'b1, SZ_BYTE, 10'h015, 32'h0, 33'h0FFFFFFA5, we, wr);
    ready_chk = 1'b0;
    drain();

    // Reset with responses queued.
    lat_chk = 1'b0;
    bus.rsp_ready = 1'b0;
    send(1'b0, 1'b0, SZ_BYTE, 10'h010, 32'h0, 33'h44, we, wr);
    send(1'b0, 1'b0, SZ_BYTE, 10'h011, 32'h0, 33'h33, we, wr);
    repeat (2) @(negedge clk);
    #1;
    chk("queued_rsp_valid", {32'h0, bus.rsp_valid}, 33'h1);
    reset_l = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("mid_reset_rsp_valid", {32'h0, bus.rsp_valid}, 33'h0);
    chk("mid_reset_rsp", {bus.rsp_err, bus.rsp_rdata}, 33'h0);
    chk("mid_reset_req_ready", {32'h0, bus.req_ready}, 33'h0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    #1;
    chk("post_reset_ready_low", {32'h0, bus.req_ready}, 33'h0);
    @(posedge clk);
    #1;
    chk("post_reset_ready_high", {32'h0, bus.req_ready}, 33'h1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b_addr[i] = 10'h010;
      b_size[i] = SZ_WORD;
      b_exp[i]  = 33'h011223344;
    end
    burst(4, 5, nh, rh);
    chk("reset_credits", 33'(nh), 33'h3);
    chk("reset_credits_ready", {32'h0, rh}, 33'h0);
    drain();

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 33'(exp_q.size()), 33'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
